mainreg_gen: RTL and testbench

Parametrised successor to the CPU main register file. It provides NREG general registers of WIDTH bits, with one write port and two architectural read ports (A, B). A constant port (C) supplies zero, all-ones or one. The top register is the index register, which gains post-increment and post-decrement with a registered wrap flag. Optional write-to-read bypass lets a value written this cycle be read in the same cycle. The block sits between the instruction decoder and the ALU operand muxes, as the drop-in replacement for the fixed 4×8 file.

---
 rtl/mainreg_pkg.sv | 27 ++
 rtl/mainreg_gen_regn_bit.sv | 25 ++
 rtl/mainreg_gen.sv | 86 ++++++++
 tb/tb_mainreg_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mainreg_pkg.sv
// Shared encodings and constant-port helper for the parametrised main register file.
package mainreg_pkg;

    typedef enum logic [1:0] {
        CS_ZERO = 2'b00,
        CS_ONES = 2'b01,
        CS_ONE  = 2'b10,
        CS_RSVD = 2'b11
    } csel_e;

    typedef enum logic [1:0] {
        IX_NONE = 2'b00,
        IX_INC  = 2'b01,
        IX_DEC  = 2'b10,
        IX_NOP  = 2'b11
    } ixop_e;

    // Bit 'pos' of the constant selected by csel; evaluated per bit so it fits any width.
    function automatic logic const_bit(input logic [1:0] csel, input int unsigned pos);
        case (csel)
            CS_ONES: return 1'b1;
            CS_ONE:  return (pos == 0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mainreg_gen_regn_bit.sv
// WIDTH-bit general register with load enable and asynchronous active-low clear.
module regn_bit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLEAR_N,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: state is updated with <= so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge CLK or negedge CLEAR_N) begin
        if (!CLEAR_N) begin
            r_q <= '0;
        end else if (LOAD) begin
            r_q <= D;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/mainreg_gen.sv
// NREG x WIDTH register file: one write port, two read ports, constant port, and an
// index register (top entry) with post-increment/decrement and a registered wrap flag.
module mainreg_gen
    import mainreg_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NREG   = 4,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [WIDTH-1:0]      IN,
    input  logic                  MRWE,
    input  logic [AW-1:0]         WA,
    input  logic [AW-1:0]         RA,
    input  logic [AW-1:0]         RB,
    input  logic [1:0]            CSEL,
    input  logic [1:0]            IXOP,
    output logic [WIDTH-1:0]      OUTA,
    output logic [WIDTH-1:0]      OUTB,
    output logic [WIDTH-1:0]      OUTC,
    output logic [WIDTH-1:0]      OIX,
    output logic                  IXC,
    output logic [NREG*WIDTH-1:0] ODUMP
);

    localparam logic [AW-1:0] IX_ADDR = AW'(NREG - 1);

    logic [WIDTH-1:0] w_regs [NREG];
    logic             w_ix_wr;
    logic [WIDTH-1:0] r_ix;
    logic             r_ixc;

    for (genvar g = 0; g < NREG - 1; g++) begin : g_gpr
        regn_bit #(.WIDTH(WIDTH)) u_reg (
            .CLK     (CLK),
            .CLEAR_N (RESET),
            .LOAD    (MRWE && (WA == AW'(g))),
            .D       (IN),
            .Q       (w_regs[g])
        );
    end

    assign w_ix_wr = MRWE && (WA == IX_ADDR);

    // A write to IX takes priority over any index op and always clears the wrap flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ix  <= '0;
            r_ixc <= 1'b0;
        end else if (w_ix_wr) begin
            r_ix  <= IN;
            r_ixc <= 1'b0;
        end else begin
            case (IXOP)
                IX_INC: begin
                    r_ix  <= r_ix + WIDTH'(1);
                    r_ixc <= (r_ix == '1);
                end
                IX_DEC: begin
                    r_ix  <= r_ix - WIDTH'(1);
                    r_ixc <= (r_ix == '0);
                end
                default: ;
            endcase
        end
    end

    assign w_regs[NREG-1] = r_ix;
    assign OIX            = r_ix;
    assign IXC            = r_ixc;

    // Forwarding uses the raw write data only; an IX inc/dec result is never bypassed.
    assign OUTA = ((BYPASS != 0) && MRWE && (WA == RA)) ? IN : w_regs[RA];
    assign OUTB = ((BYPASS != 0) && MRWE && (WA == RB)) ? IN : w_regs[RB];

    for (genvar g = 0; g < WIDTH; g++) begin : g_const
        assign OUTC[g] = const_bit(CSEL, g);
    end

    for (genvar g = 0; g < NREG; g++) begin : g_dump
        assign ODUMP[g*WIDTH +: WIDTH] = w_regs[g];
    end

endmodule

// File: tb/tb_mainreg_gen.sv
// Directed scoreboard bench: 8x4 with and without bypass sharing stimulus, plus a 16x8 instance.
module tb_mainreg_gen;

    typedef enum int {
        S_A0, S_B0, S_C0, S_IX0, S_IXC0, S_D0,
        S_A1, S_B1, S_D1,
        S_A2, S_B2, S_C2, S_IX2, S_IXC2, S_D2
    } sig_e;

    typedef struct {
        sig_e         sig;
        string        tag;
        logic [127:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    logic [7:0]  in0 = '0;
    logic        mrwe0 = 1'b0;
    logic [1:0]  wa0 = '0, ra0 = '0, rb0 = '0, csel0 = '0, ixop0 = '0;
    logic [7:0]  a0, b0, c0, ix0, a1, b1, c1, ix1;
    logic        ixc0, ixc1;
    logic [31:0] d0, d1;

    logic [15:0]  in2 = '0;
    logic         mrwe2 = 1'b0;
    logic [2:0]   wa2 = '0, ra2 = '0, rb2 = '0;
    logic [1:0]   csel2 = '0, ixop2 = '0;
    logic [15:0]  a2, b2, c2, ix2;
    logic         ixc2;
    logic [127:0] d2;

    logic [7:0] ctab [4] = '{8'h00, 8'hFF, 8'h01, 8'h00};

    always #5 CLK = ~CLK;

    mainreg_gen #(.WIDTH(8), .NREG(4), .BYPASS(1)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .IN(in0), .MRWE(mrwe0), .WA(wa0), .RA(ra0), .RB(rb0),
        .CSEL(csel0), .IXOP(ixop0), .OUTA(a0), .OUTB(b0), .OUTC(c0), .OIX(ix0), .IXC(ixc0),
        .ODUMP(d0)
    );

    mainreg_gen #(.WIDTH(8), .NREG(4), .BYPASS(0)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .IN(in0), .MRWE(mrwe0), .WA(wa0), .RA(ra0), .RB(rb0),
        .CSEL(csel0), .IXOP(ixop0), .OUTA(a1), .OUTB(b1), .OUTC(c1), .OIX(ix1), .IXC(ixc1),
        .ODUMP(d1)
    );

    mainreg_gen #(.WIDTH(16), .NREG(8), .BYPASS(1)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .IN(in2), .MRWE(mrwe2), .WA(wa2), .RA(ra2), .RB(rb2),
        .CSEL(csel2), .IXOP(ixop2), .OUTA(a2), .OUTB(b2), .OUTC(c2), .OIX(ix2), .IXC(ixc2),
        .ODUMP(d2)
    );

    function automatic logic [127:0] observe(input sig_e s);
        case (s)
            S_A0:    return 128'(a0);
            S_B0:    return 128'(b0);
            S_C0:    return 128'(c0);
            S_IX0:   return 128'(ix0);
            S_IXC0:  return 128'(ixc0);
            S_D0:    return 128'(d0);
            S_A1:    return 128'(a1);
            S_B1:    return 128'(b1);
            S_D1:    return 128'(d1);
            S_A2:    return 128'(a2);
            S_B2:    return 128'(b2);
            S_C2:    return 128'(c2);
            S_IX2:   return 128'(ix2);
            S_IXC2:  return 128'(ixc2);
            default: return 128'(d2);
        endcase
    endfunction

    task automatic push(input sig_e s, input string tag, input logic [127:0] v);
        exp_t e;
        e.sig = s;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued for this step.
    task automatic drain();
        exp_t e;
        #2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_chk++;
            assert (observe(e.sig) === e.val)
            else begin
                n_bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, observe(e.sig), e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held from time 0
        #3;
        push(S_D0, "rst_dump0", 0); push(S_IX0, "rst_ix0", 0);
        push(S_IXC0, "rst_ixc0", 0); push(S_D2, "rst_dump2", 0);
        drain();
        @(negedge CLK);
        RESET = 1'b1;

        // Load IX and reg0, then reset mid-cycle with a write and IX op pending
        tick(); mrwe0 = 1; wa0 = 3; in0 = 8'h33;
        tick(); wa0 = 0; in0 = 8'h5A;
        tick(); mrwe0 = 0; ra0 = 0;
        push(S_A0, "load_a0", 8'h5A); push(S_A1, "load_a1", 8'h5A);
        push(S_D0, "load_dump0", 32'h3300005A);
        drain();
        mrwe0 = 1; wa0 = 1; in0 = 8'hEE; ixop0 = 2'b01;
        RESET = 1'b0;
        #1;
        push(S_D0, "midrst_dump0", 0); push(S_IX0, "midrst_ix0", 0);
        push(S_IXC0, "midrst_ixc0", 0); push(S_A0, "midrst_a0", 0);
        drain();
        mrwe0 = 0; ixop0 = 0;
        RESET = 1'b1;
        tick();
        push(S_D0, "postrst_dump0", 0);
        drain();

        // Write/read on consecutive cycles
        mrwe0 = 1; wa0 = 1; in0 = 8'hC3;
        tick(); wa0 = 2; in0 = 8'h3C;
        tick(); mrwe0 = 0; ra0 = 1; rb0 = 2;
        push(S_A0, "wr_a", 8'hC3); push(S_B0, "wr_b", 8'h3C);
        push(S_D0, "wr_dump", 32'h003CC300);
        drain();

        // Same-cycle bypass vs. pre-edge read
        mrwe0 = 1; wa0 = 0; in0 = 8'h11;
        tick(); in0 = 8'h77; ra0 = 0;
        push(S_A0, "byp_same_a0", 8'h77); push(S_A1, "nobyp_same_a1", 8'h11);
        drain();
        tick(); mrwe0 = 0;
        push(S_A0, "byp_after_a0", 8'h77); push(S_A1, "nobyp_after_a1", 8'h77);
        drain();

        // IX wrap upward, then back down, then hold
        mrwe0 = 1; wa0 = 3; in0 = 8'hFE;
        tick(); mrwe0 = 0; ixop0 = 2'b01;
        push(S_IX0, "ix_fe", 8'hFE); push(S_IXC0, "ixc_fe", 0);
        drain();
        tick();
        push(S_IX0, "ix_ff", 8'hFF); push(S_IXC0, "ixc_ff", 0);
        drain();
        tick(); ixop0 = 2'b10; ra0 = 3;
        push(S_IX0, "ix_wrap0", 8'h00); push(S_IXC0, "ixc_wrap0", 1);
        push(S_A0, "ix_read_preedge", 8'h00);
        drain();
        tick(); ixop0 = 2'b00;
        push(S_IX0, "ix_dec_ff", 8'hFF); push(S_IXC0, "ixc_dec_ff", 1);
        drain();
        tick();
        push(S_IXC0, "ixc_hold", 1);
        drain();

        // Write to IX alongside an increment: write wins, flag cleared
        mrwe0 = 1; wa0 = 3; in0 = 8'h80; ixop0 = 2'b01; rb0 = 3;
        push(S_B0, "byp_ix_b0", 8'h80); push(S_B1, "nobyp_ix_b1", 8'hFF);
        drain();
        tick(); mrwe0 = 0; ixop0 = 0;
        push(S_IX0, "conf_ix", 8'h80); push(S_IXC0, "conf_ixc", 0);
        drain();

        // Write to reg0 with a decrement: both apply
        mrwe0 = 1; wa0 = 0; in0 = 8'h42; ixop0 = 2'b10; ra0 = 3;
        push(S_A0, "ixop_read_a0", 8'h80);
        drain();
        tick(); mrwe0 = 0; ixop0 = 0;
        push(S_IX0, "both_ix", 8'h7F); push(S_IXC0, "both_ixc", 0);
        push(S_D0, "both_dump0", 32'h7F3CC342); push(S_D1, "both_dump1", 32'h7F3CC342);
        drain();

        // IX op result is not forwarded to the read port
        ixop0 = 2'b01; rb0 = 3;
        push(S_B0, "no_ixop_fwd", 8'h7F);
        drain();
        tick(); ixop0 = 0;
        push(S_B0, "ixop_after", 8'h80);
        drain();

        for (int i = 0; i < 4; i++) begin
            csel0 = 2'(i);
            push(S_C0, $sformatf("const_%0d", i), 128'(ctab[i]));
            drain();
        end

        // 16-bit, 8-register instance
        mrwe2 = 1; wa2 = 1; in2 = 16'hC3A5;
        tick(); wa2 = 2; in2 = 16'h3C5A;
        tick(); wa2 = 6; in2 = 16'h1234;
        tick(); mrwe2 = 0; ra2 = 1; rb2 = 6;
        push(S_A2, "w16_a", 16'hC3A5); push(S_B2, "w16_b", 16'h1234);
        push(S_D2, "w16_dump", 128'h0000_1234_0000_0000_0000_3C5A_C3A5_0000);
        drain();
        ra2 = 2;
        push(S_A2, "w16_a2", 16'h3C5A);
        drain();

        mrwe2 = 1; wa2 = 7; in2 = 16'hFFFE;
        tick(); mrwe2 = 0; ixop2 = 2'b01;
        push(S_IX2, "w16_ix_fffe", 16'hFFFE);
        drain();
        tick();
        push(S_IX2, "w16_ix_ffff", 16'hFFFF); push(S_IXC2, "w16_ixc_ffff", 0);
        drain();
        tick(); ixop2 = 2'b10;
        push(S_IX2, "w16_ix_wrap", 16'h0000); push(S_IXC2, "w16_ixc_wrap", 1);
        drain();
        tick(); ixop2 = 2'b00;
        push(S_IX2, "w16_ix_dec", 16'hFFFF); push(S_IXC2, "w16_ixc_dec", 1);
        drain();
        csel2 = 2'b01;
        push(S_C2, "w16_ones", 16'hFFFF);
        drain();
        csel2 = 2'b10;
        push(S_C2, "w16_one", 16'h0001);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
